// File: rtl/smart_home_zone_ctrl.sv
// smart_home_zone_ctrl: per-zone occupancy lighting and fan hysteresis, plus a
// shared arm/entry/alarm security FSM that records which zones caused an intrusion.

// One zone: light hold-off counter and fan hysteresis, both registered.
module smart_home_zone_lane #(
  parameter int TEMP_W     = 8,
  parameter int TEMP_ON    = 30,
  parameter int TEMP_OFF   = 27,
  parameter int LIGHT_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              motion,
  input  logic              dark,
  input  logic              manual_override,
  input  logic [TEMP_W-1:0] temp,
  output logic              light_on,
  output logic              fan_on
);
  localparam int HW = $clog2(LIGHT_HOLD + 1);
  localparam logic [TEMP_W-1:0] T_ON  = TEMP_W'(TEMP_ON);
  localparam logic [TEMP_W-1:0] T_OFF = TEMP_W'(TEMP_OFF);

  logic          trig;
  logic [HW-1:0] hcnt, hcnt_nxt;

  // Reload on trigger, otherwise count down and stop at zero.
  always_comb begin
    trig     = manual_override | (motion & dark);
    hcnt_nxt = hcnt;
    if (trig)            hcnt_nxt = HW'(LIGHT_HOLD);
    else if (hcnt != '0) hcnt_nxt = hcnt - 1'b1;
  end

  // Light follows the post-update counter so it drops exactly LIGHT_HOLD edges after the last trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt     <= '0;
      light_on <= 1'b0;
    end else begin
      hcnt     <= hcnt_nxt;
      light_on <= (hcnt_nxt != '0);
    end
  end

  // Fan hysteresis: above TEMP_ON sets, below TEMP_OFF clears, inside the band holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             fan_on <= 1'b0;
    else if (temp > T_ON)   fan_on <= 1'b1;
    else if (temp < T_OFF)  fan_on <= 1'b0;
  end
endmodule

// Top: array of zone lanes plus the shared security FSM.
module smart_home_zone_ctrl #(
  parameter int N_ZONES     = 4,
  parameter int TEMP_W      = 8,
  parameter int TEMP_ON     = 30,
  parameter int TEMP_OFF    = 27,
  parameter int LIGHT_HOLD  = 16,
  parameter int ENTRY_DELAY = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_ZONES-1:0]        motion,
  input  logic [N_ZONES-1:0]        dark,
  input  logic [N_ZONES-1:0]        manual_override,
  input  logic [N_ZONES*TEMP_W-1:0] temp,
  input  logic                      arm,
  input  logic                      disarm,
  output logic [N_ZONES-1:0]        light_on,
  output logic [N_ZONES-1:0]        fan_on,
  output logic                      alarm,
  output logic [1:0]                alarm_state,
  output logic [N_ZONES-1:0]        trip_zones
);
  localparam int EW = $clog2(ENTRY_DELAY + 1);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_ENTRY    = 2'd2,
    S_ALARM    = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [EW-1:0]      etimer, etimer_nxt;
  logic [N_ZONES-1:0] trip_nxt;
  logic [N_ZONES-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_ZONES; gi++) begin : g_zone
      smart_home_zone_lane #(
        .TEMP_W    (TEMP_W),
        .TEMP_ON   (TEMP_ON),
        .TEMP_OFF  (TEMP_OFF),
        .LIGHT_HOLD(LIGHT_HOLD)
      ) u_lane (
        .clk            (clk),
        .rst_n          (rst_n),
        .motion         (motion[gi]),
        .dark           (dark[gi]),
        .manual_override(manual_override[gi]),
        .temp           (temp[gi*TEMP_W +: TEMP_W]),
        .light_on       (light_on[gi]),
        .fan_on         (fan_on[gi])
      );
    end
  endgenerate

  // Motion in a zone nobody has claimed by override counts as intrusion.
  assign hit = motion & ~manual_override;

  // Security next-state: disarm always wins; trip capture is sticky in ENTRY/ALARM.
  always_comb begin
    state_nxt  = state;
    etimer_nxt = etimer;
    trip_nxt   = trip_zones;
    unique case (state)
      S_DISARMED: begin
        if (arm && !disarm) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (disarm) begin
          state_nxt = S_DISARMED;
        end else if (|hit) begin
          state_nxt  = S_ENTRY;
          etimer_nxt = EW'(ENTRY_DELAY);
          trip_nxt   = hit;
        end
      end
      S_ENTRY: begin
        trip_nxt = trip_zones | hit;
        if (etimer == EW'(1)) begin
          state_nxt  = S_ALARM;
          etimer_nxt = '0;
        end else begin
          etimer_nxt = etimer - 1'b1;
        end
      end
      S_ALARM: begin
        trip_nxt = trip_zones | hit;
      end
      default: state_nxt = S_DISARMED;
    endcase
    // Disarm overrides everything above, including an expiring entry timer.
    if (disarm && state != S_DISARMED) begin
      state_nxt  = S_DISARMED;
      etimer_nxt = '0;
      trip_nxt   = '0;
    end
  end

  // Security state, timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_DISARMED;
      etimer     <= '0;
      trip_zones <= '0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_nxt;
      etimer     <= etimer_nxt;
      trip_zones <= trip_nxt;
      alarm      <= (state_nxt == S_ALARM);
    end
  end

  assign alarm_state = state;
endmodule

// File: tb/tb_smart_home_zone_ctrl.sv
// Directed + randomized bench for smart_home_zone_ctrl with a time-based reference model.
module tb_smart_home_zone_ctrl;
  localparam int NZ = 4;
  localparam int HOLD = 16;
  localparam int EDLY = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NZ-1:0] motion, dark, mo;
  logic [31:0]   temp;
  logic          arm, disarm;
  logic [NZ-1:0] light_on, fan_on, trip_zones;
  logic          alarm;
  logic [1:0]    alarm_state;

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed as event times rather than counters.
  int            ecnt;
  int            last_trig [NZ];
  logic [NZ-1:0] fan_m, light_m, trip_m;
  int            st_m;
  int            ent_edge;

  smart_home_zone_ctrl dut (
    .clk(clk), .rst_n(rst_n), .motion(motion), .dark(dark),
    .manual_override(mo), .temp(temp), .arm(arm), .disarm(disarm),
    .light_on(light_on), .fan_on(fan_on), .alarm(alarm),
    .alarm_state(alarm_state), .trip_zones(trip_zones)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NZ; i++) last_trig[i] = -1000;
    fan_m = '0; light_m = '0; trip_m = '0; st_m = 0; ent_edge = 0;
  endtask

  // Apply the spec rules for the inputs present at edge number ecnt.
  task automatic model_edge();
    logic [NZ-1:0] h;
    int t;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NZ; i++) begin
      if (mo[i] || (motion[i] && dark[i])) last_trig[i] = ecnt;
      light_m[i] = (ecnt - last_trig[i]) < HOLD;
      t = int'(temp[i*8 +: 8]);
      if (t > 30) fan_m[i] = 1'b1;
      else if (t < 27) fan_m[i] = 1'b0;
    end
    h = motion & ~mo;
    case (st_m)
      0: if (arm && !disarm) st_m = 1;
      1: if (disarm) st_m = 0;
         else if (h != 0) begin st_m = 2; ent_edge = ecnt; trip_m = h; end
      2: if (disarm) begin st_m = 0; trip_m = '0; end
         else begin
           trip_m |= h;
           if (ecnt - ent_edge == EDLY) st_m = 3;
         end
      default: if (disarm) begin st_m = 0; trip_m = '0; end
               else trip_m |= h;
    endcase
  endtask

  task automatic check_all();
    chk("light_on", 32'(light_on), 32'(light_m));
    chk("fan_on", 32'(fan_on), 32'(fan_m));
    chk("alarm_state", 32'(alarm_state), 32'(st_m));
    chk("alarm", 32'(alarm), 32'(st_m == 3));
    chk("trip_zones", 32'(trip_zones), 32'(trip_m));
  endtask

  // One clock edge: advance model, sample 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    ecnt++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic quiet();
    motion = '0; dark = '0; mo = '0; arm = 1'b0; disarm = 1'b0;
  endtask

  int fan_seq [6] = '{25, 29, 31, 29, 27, 26};
  logic [5:0] fan_exp = 6'b011100; // bit j = expected fan after step j

  initial begin
    ecnt = 0;
    model_reset();
    // Reset with every input asserted: outputs must stay zero.
    rst_n = 1'b0; motion = '1; dark = '1; mo = '1; arm = 1'b1; disarm = 1'b1;
    temp = {4{8'd40}};
    #1;
    check_all();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_release_light", 32'(light_on), 32'hF);
    chk("rst_release_fan", 32'(fan_on), 32'hF);
    chk("arm_disarm_together", 32'(alarm_state), 32'd0);

    // Light hold and retrigger on zone 0; zone 1 has motion but is not dark.
    quiet(); temp = '0;
    repeat (20) tick();
    dark = 4'b0001; motion = 4'b0011;
    tick();
    chk("light_first_edge", 32'(light_on[0]), 32'd1);
    for (int j = 1; j <= 16; j++) begin
      motion[0] = 1'b0;
      tick();
      if (j == 15) chk("light_k15", 32'(light_on[0]), 32'd1);
      if (j == 16) chk("light_k16", 32'(light_on[0]), 32'd0);
    end
    chk("light_not_dark", 32'(light_on[1]), 32'd0);
    motion[0] = 1'b1;
    tick();
    for (int j = 1; j <= 26; j++) begin
      motion[0] = (j == 10);
      tick();
      if (j == 25) chk("retrig_k25", 32'(light_on[0]), 32'd1);
      if (j == 26) chk("retrig_k26", 32'(light_on[0]), 32'd0);
    end
    quiet();

    // Fan hysteresis on zone 0.
    for (int j = 0; j < 6; j++) begin
      temp[7:0] = 8'(fan_seq[j]);
      tick();
      chk("fan_seq", 32'(fan_on[0]), 32'(fan_exp[j]));
    end
    temp = '0;

    // Arm, intrusion in zone 2, zone 3 joins, alarm after exactly EDLY edges.
    arm = 1'b1; tick(); arm = 1'b0;
    chk("armed", 32'(alarm_state), 32'd1);
    motion = 4'b0100; tick();
    chk("entry_state", 32'(alarm_state), 32'd2);
    chk("entry_trip", 32'(trip_zones), 32'b0100);
    motion = '0;
    repeat (5) tick();
    motion = 4'b1000; tick();
    chk("trip_join", 32'(trip_zones), 32'b1100);
    motion = '0;
    for (int j = 7; j <= 31; j++) tick();
    chk("no_alarm_early", 32'(alarm), 32'd0);
    tick();
    chk("alarm_on_time", 32'(alarm), 32'd1);
    arm = 1'b1; repeat (5) tick(); arm = 1'b0;
    chk("alarm_latched", 32'(alarm), 32'd1);
    disarm = 1'b1; tick(); disarm = 1'b0;
    chk("disarm_alarm", 32'(alarm_state), 32'd0);
    chk("disarm_trip_clr", 32'(trip_zones), 32'd0);

    // Disarm on the edge entry would expire.
    arm = 1'b1; tick(); arm = 1'b0;
    motion = 4'b0001; tick(); motion = '0;
    for (int j = 1; j <= 31; j++) tick();
    disarm = 1'b1; tick();
    chk("race_state", 32'(alarm_state), 32'd0);
    chk("race_alarm", 32'(alarm), 32'd0);
    chk("race_trip", 32'(trip_zones), 32'd0);
    arm = 1'b1; tick();
    chk("both_disarmed", 32'(alarm_state), 32'd0);
    quiet();

    // Override masks intrusion; then reach ALARM and reset asynchronously.
    arm = 1'b1; tick(); arm = 1'b0;
    motion = 4'b0010; mo = 4'b0010; tick();
    chk("override_armed", 32'(alarm_state), 32'd1);
    mo = '0; tick();
    chk("override_entry", 32'(alarm_state), 32'd2);
    motion = '0;
    repeat (EDLY) tick();
    chk("alarm_before_rst", 32'(alarm), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_alarm", 32'(alarm), 32'd0);
    chk("async_rst_state", 32'(alarm_state), 32'd0);
    check_all();
    tick();
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      motion = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      dark   = 4'($urandom_range(0, 15));
      mo     = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      for (int i = 0; i < NZ; i++) temp[i*8 +: 8] = 8'($urandom_range(20, 36));
      arm    = ($urandom_range(0, 9) == 0);
      disarm = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) != 0) motion = '0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
